param_data_memory: RTL

PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

---
 rtl/param_data_memory.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/param_data_memory.sv
// rtl/param_data_memory.sv - word memory with wait states, byte-enable writes and address range checking
module param_data_memory #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic [ADDR_WIDTH-1:0]   readAddress,
    input  logic [ADDR_WIDTH-1:0]   writeAddress,
    input  logic [DATA_WIDTH-1:0]   writeData,
    input  logic [DATA_WIDTH/8-1:0] byteEnable,
    output logic [DATA_WIDTH-1:0]   readData,
    output logic                    readValid,
    output logic                    busy,
    output logic                    addrError
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_A   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]          WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    rd_req_q, rd_req_d;
    logic                    wr_req_q, wr_req_d;
    logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]           be_q, be_d;
    logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
    logic                    read_valid_q, read_valid_d;
    logic                    addr_err_q, addr_err_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   merged_word;
    logic [IDX_W-1:0]        raddr_idx, waddr_idx;
    logic                    rd_oob, wr_oob;

    assign raddr_idx = raddr_q[IDX_W-1:0];
    assign waddr_idx = waddr_q[IDX_W-1:0];
    assign rd_oob    = ({1'b0, raddr_q} >= DEPTH_A);
    assign wr_oob    = ({1'b0, waddr_q} >= DEPTH_A);

    // Stored word at the write address with the enabled bytes replaced by write data.
    always_comb begin
        merged_word = mem_q[waddr_idx];
        for (int b = 0; b < NB; b++) begin
            if (be_q[b]) begin
                merged_word[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    // Next-state logic: accept in IDLE, count wait states, complete the access.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_req_d     = rd_req_q;
        wr_req_d     = wr_req_q;
        raddr_d      = raddr_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        addr_err_d   = 1'b0;
        mem_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    rd_req_d = MemRead;
                    wr_req_d = MemWrite;
                    raddr_d  = readAddress;
                    waddr_d  = writeAddress;
                    wdata_d  = writeData;
                    be_d     = byteEnable;
                    cnt_d    = WAIT_INIT;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    mem_we  = wr_req_q && !wr_oob && (be_q != '0);
                    if (rd_req_q) begin
                        read_valid_d = 1'b1;
                        if (rd_oob) begin
                            read_data_d = '0;
                        end else if (mem_we && (raddr_q == waddr_q)) begin
                            read_data_d = merged_word;
                        end else begin
                            read_data_d = mem_q[raddr_idx];
                        end
                    end
                    addr_err_d = (rd_req_q && rd_oob) || (wr_req_q && wr_oob);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control, latched request and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            raddr_q      <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
            raddr_q      <= raddr_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    // Storage array; cleared by reset, written only at an in-range write completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[waddr_idx] <= merged_word;
        end
    end

    assign readData  = read_data_q;
    assign readValid = read_valid_q;
    assign addrError = addr_err_q;
    assign busy      = (state_q == ACCESS);

endmodule
